// File: rtl/bcd_to_binary_seq_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
interface bcd_to_binary_seq_if;
  logic       start;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, hundreds, tens, ones,
    input  bin, busy, done, err
  );

  modport slave (
    input  start, hundreds, tens, ones,
    output bin, busy, done, err
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Three-digit BCD to 8-bit binary converter using reverse double-dabble, one bit per cycle.
// Define BCD2BIN_SAT_EN to saturate overflowing results to 8'hFF instead of wrapping mod 256.
module bcd_to_binary_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_to_binary_seq_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  res_q, res_d;
  logic        err_q, err_d;

  logic [11:0] sh_bcd;
  logic [7:0]  sh_acc;
  logic [11:0] adj_bcd;
  logic        digit_bad;
  logic        ovf;
  logic [7:0]  ovf_val;

  // One reverse double-dabble step on the working registers.
  always_comb begin
    {sh_bcd, sh_acc} = {bcd_q, acc_q} >> 1;
    adj_bcd = sh_bcd;
    for (int i = 0; i < 3; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8) begin
        adj_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
      end
    end
  end

  assign digit_bad = (bcd_q[3:0] > 4'd9) || (bcd_q[7:4] > 4'd9) || (bcd_q[11:8] > 4'd9);
  // Any residual BCD left after eight steps means the value did not fit in 8 bits.
  assign ovf       = |adj_bcd;

`ifdef BCD2BIN_SAT_EN
  assign ovf_val = 8'hFF;
`else
  assign ovf_val = sh_acc;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          bcd_d   = {bus.hundreds, bus.tens, bus.ones};
          acc_d   = 8'h00;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (digit_bad) begin
          res_d   = 8'h00;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d   = 3'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = adj_bcd;
        acc_d = sh_acc;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          err_d   = ovf;
          res_d   = ovf ? ovf_val : sh_acc;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      bcd_q   <= 12'h000;
      acc_q   <= 8'h00;
      res_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.bin  = res_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q == StCheck) || (state_q == StShift);
  assign bus.done = (state_q == StDone);

endmodule
